color_gen_param: RTL and testbench
==================================

Name: color_gen_param

Overview:
Parametrised successor of the hue-wheel RGBW colour generator. It converts a hue index, a white level and an intensity into RGBW channel levels, or passes RGBW through directly. Versus the previous generation it adds:
- generic channel width;
- configurable segment length and ramp step;
- saturating ramps;
- true multiplicative intensity (serial shift-add) instead of power-of-two shifts;
- an explicit start/busy/valid handshake.

It sits between the command decoder and the PWM channel drivers.

Parameters:
DW, 8, channel/intensity width; MAX = 2^DW-1
HUE_W, 8, colour index width
SEG_LEN, 36, hue steps per wheel segment (6 segments); 6*SEG_LEN <= 2^HUE_W
STEP, 7, ramp increment per hue step
MODE_DIRECT, 8'h21, pass-through mode code
MODE_HUE, 8'hA4, hue-wheel mode code

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
mode  in  8  mode code, sampled only with start
start  in  1  request pulse; ignored while busy=1
lint  in  DW  intensity; MAX = full scale
color_idx  in  HUE_W  hue index
white_in, red_in, green_in, blue_in  in  DW each  white level / direct-mode levels
busy  out  1  high from the edge after an accepted start until valid
valid  out  1  one-cycle pulse, coincident with the output update
red_out, green_out, blue_out, white_out  out  DW each  registered channel levels

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; busy=0, valid=0; internal registers cleared. Reset mid-operation aborts the operation; no valid is produced.
- States: IDLE, SWEEP, MIX, SCALE, APPLY.
- IDLE, start=1, mode=MODE_DIRECT:
  - On the same edge, outputs <= the four *_in values and valid=1.
  - Latency 1 edge; busy stays 0.
- IDLE, start=1, mode=MODE_HUE:
  - Latch h = min(color_idx, 6*SEG_LEN-1), white_in and lint.
  - Go to SWEEP with counter=0, ramp=0.
- IDLE, start=1, any other mode: ignored; no valid.
- SWEEP, each cycle:
  - Compute segment s = counter/SEG_LEN and offset o.
  - ramp resets to 0 at each segment boundary; otherwise ramp <= min(MAX, ramp+STEP), i.e. ramp = min(MAX, o*STEP).
  - Exit to MIX when counter==h, after h+1 cycles.
  - Channel values by segment:
    - s0: R=MAX, G=0, B=ramp
    - s1: R=MAX-ramp, G=0, B=MAX
    - s2: R=0, G=ramp, B=MAX
    - s3: R=0, G=MAX, B=MAX-ramp
    - s4: R=ramp, G=MAX, B=0
    - s5: R=MAX, G=MAX-ramp, B=0
- MIX (1 cycle): R, G, B each <= min(MAX, c+white); DW+1-bit sum; no wrap.
- SCALE (DW cycles): all four channels (R, G, B, W) computed in parallel as out = (c*(lint+1)) >> DW, via serial shift-add over a 2*DW-bit accumulator.
  - lint=MAX gives an exact copy of the input.
  - lint=0 gives c>>DW, which is 0.
- APPLY (1 cycle): outputs registered, valid=1, busy=0, return to IDLE.
- Hue latency: outputs and valid appear exactly h+DW+3 edges after the start-accepting edge (11 for h=0, DW=8).
- start asserted while busy: ignored, not queued.
- Outputs hold their last value between updates.

Decomposition:
- Package color_gen_pkg: mode code constants, state enum (3-bit), segment count constant 6.
- Sub-module lint_scaler: DW-cycle serial multiply-shift for one channel with load/done. Instantiated 4x, sharing one control counter.

Test Plan:
- Direct: mode=21, start, R/G/B/W=12/34/56/78 -> next edge outputs 12/34/56/78, valid 1 cycle, busy never 1.
- Hue 0: idx=0, white=0, lint=FF -> R/G/B/W=FF/00/00/00 exactly 11 edges after start; busy high 10 cycles.
- Hue 40 (s1, o=4): lint=FF -> R=E3, G=00, B=FF, W=00.
- White saturation: idx=108 (s3, o=0), white=10, lint=FF -> R=10, G=FF, B=FF, W=10.
- Intensity: idx=0, white=0, lint=7F -> R=7F, G=0, B=0. Clamp: idx=FA with lint=FF -> h=215, ramp=F5, R=FF, G=0A, B=00.
- Robustness:
  - start during busy -> ignored, single valid.
  - reset asserted mid-SCALE -> outputs 0 immediately, no valid.
  - mode=55 with start -> no response.

Source files
------------

// File: rtl/color_gen_pkg.sv
// Shared constants and state encoding for the parametrised RGBW colour generator.
package color_gen_pkg;

    localparam logic [7:0] MODE_DIRECT_C = 8'h21;
    localparam logic [7:0] MODE_HUE_C    = 8'hA4;
    localparam int         NUM_SEG       = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWEEP = 3'd1,
        ST_MIX   = 3'd2,
        ST_SCALE = 3'd3,
        ST_APPLY = 3'd4
    } state_t;

endpackage

// File: rtl/color_gen_param_lint_scaler.sv
// One channel of the intensity multiplier: out = (c * (lint + 1)) >> DW,
// built one multiplier bit per step; load seeds the +c term.
module lint_scaler #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] lint_i,
    output logic [DW-1:0] prod_o
);

    logic [2*DW-1:0] acc_q, acc_d;
    logic [2*DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0]   mult_q, mult_d;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        if (load_i) begin
            acc_d   = {{DW{1'b0}}, c_i};
            mcand_d = {{DW{1'b0}}, c_i};
            mult_d  = lint_i;
        end else if (step_i) begin
            if (mult_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
        end
    end

    assign prod_o = acc_q[2*DW-1:DW];

endmodule

// File: rtl/color_gen_param.sv
// Hue-wheel / direct RGBW colour generator with white mix and multiplicative
// intensity; a start pulse is answered by a one-cycle valid with new outputs.
module color_gen_param
    import color_gen_pkg::*;
#(
    parameter int         DW          = 8,
    parameter int         HUE_W       = 8,
    parameter int         SEG_LEN     = 36,
    parameter int         STEP        = 7,
    parameter logic [7:0] MODE_DIRECT = MODE_DIRECT_C,
    parameter logic [7:0] MODE_HUE    = MODE_HUE_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       mode,
    input  logic             start,
    input  logic [DW-1:0]    lint,
    input  logic [HUE_W-1:0] color_idx,
    input  logic [DW-1:0]    white_in,
    input  logic [DW-1:0]    red_in,
    input  logic [DW-1:0]    green_in,
    input  logic [DW-1:0]    blue_in,
    output logic             busy,
    output logic             valid,
    output logic [DW-1:0]    red_out,
    output logic [DW-1:0]    green_out,
    output logic [DW-1:0]    blue_out,
    output logic [DW-1:0]    white_out,
    output logic [2:0]       dbg_state
);

    localparam logic [DW-1:0]    MAX      = '1;
    localparam logic [HUE_W-1:0] H_LAST   = HUE_W'(NUM_SEG * SEG_LEN - 1);
    localparam logic [HUE_W-1:0] OFF_LAST = HUE_W'(SEG_LEN - 1);
    localparam int               CW       = $clog2(DW + 1);

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? MAX : s[DW-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [HUE_W-1:0] h_q, h_d;
    logic [HUE_W-1:0] counter_q, counter_d;
    logic [HUE_W-1:0] off_q, off_d;
    logic [2:0]       seg_q, seg_d;
    logic [DW-1:0]    ramp_q, ramp_d;
    logic [DW-1:0]    white_q, white_d;
    logic [DW-1:0]    lint_q, lint_d;
    logic [CW-1:0]    sc_cnt_q, sc_cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [DW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d, w_q, w_d;

    logic [DW-1:0] chan_r, chan_g, chan_b;
    logic [DW-1:0] mix_r, mix_g, mix_b;
    logic [DW-1:0] prod_r, prod_g, prod_b, prod_w;
    logic          sc_load, sc_step;

    // Wheel colour for the segment/ramp reached when the sweep stops.
    always_comb begin
        chan_r = '0;
        chan_g = '0;
        chan_b = '0;
        case (seg_q)
            3'd0: begin chan_r = MAX;          chan_b = ramp_q;       end
            3'd1: begin chan_r = MAX - ramp_q; chan_b = MAX;          end
            3'd2: begin chan_g = ramp_q;       chan_b = MAX;          end
            3'd3: begin chan_g = MAX;          chan_b = MAX - ramp_q; end
            3'd4: begin chan_r = ramp_q;       chan_g = MAX;          end
            default: begin chan_r = MAX;       chan_g = MAX - ramp_q; end
        endcase
    end

    assign mix_r = sat_add(chan_r, white_q);
    assign mix_g = sat_add(chan_g, white_q);
    assign mix_b = sat_add(chan_b, white_q);

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        counter_d = counter_q;
        off_d     = off_q;
        seg_d     = seg_q;
        ramp_d    = ramp_q;
        white_d   = white_q;
        lint_d    = lint_q;
        sc_cnt_d  = sc_cnt_q;
        valid_d   = 1'b0;
        busy_d    = (state_q == ST_SWEEP) || (state_q == ST_MIX) || (state_q == ST_SCALE);
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        w_d       = w_q;
        sc_load   = 1'b0;
        sc_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mode == MODE_DIRECT) begin
                    r_d     = red_in;
                    g_d     = green_in;
                    b_d     = blue_in;
                    w_d     = white_in;
                    valid_d = 1'b1;
                end else if (start && mode == MODE_HUE) begin
                    h_d       = (color_idx > H_LAST) ? H_LAST : color_idx;
                    white_d   = white_in;
                    lint_d    = lint;
                    counter_d = '0;
                    off_d     = '0;
                    seg_d     = '0;
                    ramp_d    = '0;
                    state_d   = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (counter_q == h_q) begin
                    state_d = ST_MIX;
                end else begin
                    counter_d = counter_q + HUE_W'(1);
                    if (off_q == OFF_LAST) begin
                        off_d  = '0;
                        seg_d  = seg_q + 3'd1;
                        ramp_d = '0;
                    end else begin
                        off_d  = off_q + HUE_W'(1);
                        ramp_d = sat_add(ramp_q, DW'(STEP));
                    end
                end
            end
            ST_MIX: begin
                sc_load  = 1'b1;
                sc_cnt_d = '0;
                state_d  = ST_SCALE;
            end
            ST_SCALE: begin
                sc_step = 1'b1;
                if (sc_cnt_q == CW'(DW - 1)) begin
                    state_d = ST_APPLY;
                end else begin
                    sc_cnt_d = sc_cnt_q + CW'(1);
                end
            end
            ST_APPLY: begin
                r_d     = prod_r;
                g_d     = prod_g;
                b_d     = prod_b;
                w_d     = prod_w;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            counter_q <= '0;
            off_q     <= '0;
            seg_q     <= '0;
            ramp_q    <= '0;
            white_q   <= '0;
            lint_q    <= '0;
            sc_cnt_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            counter_q <= counter_d;
            off_q     <= off_d;
            seg_q     <= seg_d;
            ramp_q    <= ramp_d;
            white_q   <= white_d;
            lint_q    <= lint_d;
            sc_cnt_q  <= sc_cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            w_q       <= w_d;
        end
    end

    // Four identical scalers stepped by the single SCALE counter above.
    lint_scaler #(.DW(DW)) u_scale_r (
        .clk(clk), .reset(reset), .load_i(sc_load), .step_i(sc_step),
        .c_i(mix_r), .lint_i(lint_q), .prod_o(prod_r)
    );
    lint_scaler #(.DW(DW)) u_scale_g (
        .clk(clk), .reset(reset), .load_i(sc_load), .step_i(sc_step),
        .c_i(mix_g), .lint_i(lint_q), .prod_o(prod_g)
    );
    lint_scaler #(.DW(DW)) u_scale_b (
        .clk(clk), .reset(reset), .load_i(sc_load), .step_i(sc_step),
        .c_i(mix_b), .lint_i(lint_q), .prod_o(prod_b)
    );
    lint_scaler #(.DW(DW)) u_scale_w (
        .clk(clk), .reset(reset), .load_i(sc_load), .step_i(sc_step),
        .c_i(white_q), .lint_i(lint_q), .prod_o(prod_w)
    );

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign red_out   = r_q;
    assign green_out = g_q;
    assign blue_out  = b_q;
    assign white_out = w_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_color_gen_param.sv
// Scoreboard bench for color_gen_param: driver pushes model results, a negedge
// monitor pops them whenever valid is seen and also checks output hold.
module tb_color_gen_param;

  localparam int DW = 8;
  localparam int H_LAST = 6 * 36 - 1;
  localparam logic [7:0] M_DIRECT = 8'h21;
  localparam logic [7:0] M_HUE = 8'hA4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mode = '0;
  logic start = 1'b0;
  logic [7:0] lint = '0;
  logic [7:0] color_idx = '0;
  logic [7:0] white_in = '0, red_in = '0, green_in = '0, blue_in = '0;
  logic busy, valid;
  logic [7:0] red_out, green_out, blue_out, white_out;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int cyc_q[$];
  int busy_q[$];

  color_gen_param dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .lint(lint),
    .color_idx(color_idx), .white_in(white_in), .red_in(red_in),
    .green_in(green_in), .blue_in(blue_in), .busy(busy), .valid(valid),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .white_out(white_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: hue wheel arithmetic straight from the colour rules
  function automatic logic [31:0] hue_model(input int idx, input int wh, input int li);
    int h, s, o, ramp;
    int c[3];
    int res[4];
    h = (idx > H_LAST) ? H_LAST : idx;
    s = h / 36;
    o = h % 36;
    ramp = (o * 7 > 255) ? 255 : o * 7;
    case (s)
      0: c = '{255, 0, ramp};
      1: c = '{255 - ramp, 0, 255};
      2: c = '{0, ramp, 255};
      3: c = '{0, 255, 255 - ramp};
      4: c = '{ramp, 255, 0};
      default: c = '{255, 255 - ramp, 0};
    endcase
    for (int i = 0; i < 3; i++) begin
      c[i] = c[i] + wh;
      if (c[i] > 255) c[i] = 255;
      res[i] = (c[i] * (li + 1)) / 256;
    end
    res[3] = (wh * (li + 1)) / 256;
    return {8'(res[0]), 8'(res[1]), 8'(res[2]), 8'(res[3])};
  endfunction

  // monitor
  initial begin
    logic [31:0] held, e;
    int ec, eb, busy_cnt;
    held = '0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = '0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual valid=1 required no response (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            ec = cyc_q.pop_front();
            eb = busy_q.pop_front();
            chk("outputs_rgbw", {red_out, green_out, blue_out, white_out}, e);
            chk("valid_cycle", cyc, ec);
            chk("busy_cycles", busy_cnt, eb);
            held = e;
          end
          busy_cnt = 0;
        end else begin
          chk("hold", {red_out, green_out, blue_out, white_out}, held);
        end
      end
    end
  end

  // driver
  task automatic issue(input logic [7:0] m, input int idx, input int wh, input int li,
                       input int r, input int g, input int b, input int poke_at,
                       input bit abort_op);
    int h;
    @(negedge clk);
    mode = m;
    color_idx = 8'(idx);
    white_in = 8'(wh);
    lint = 8'(li);
    red_in = 8'(r);
    green_in = 8'(g);
    blue_in = 8'(b);
    start = 1'b1;
    h = (idx > H_LAST) ? H_LAST : idx;
    if (!abort_op) begin
      if (m == M_DIRECT) begin
        exp_q.push_back({8'(r), 8'(g), 8'(b), 8'(wh)});
        cyc_q.push_back(cyc + 1);
        busy_q.push_back(0);
      end else if (m == M_HUE) begin
        exp_q.push_back(hue_model(idx, wh, li));
        cyc_q.push_back(cyc + 1 + h + DW + 3);
        busy_q.push_back(h + DW + 2);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 8'($urandom);
    color_idx = 8'($urandom);
    white_in = 8'($urandom);
    lint = 8'($urandom);
    red_in = 8'($urandom);
    green_in = 8'($urandom);
    blue_in = 8'($urandom);
    if (m == M_HUE && abort_op) begin
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_outputs", {red_out, green_out, blue_out, white_out}, 32'h0);
      chk("abort_valid", 32'(valid), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_state", 32'(dbg_state), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (h + DW + 6) @(posedge clk);
    end else if (m == M_HUE) begin
      for (int k = 0; k < h + DW + 3; k++) begin
        if (k == poke_at) begin
          @(negedge clk);
          mode = M_DIRECT;
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end else begin
          @(posedge clk);
        end
      end
    end else if (m != M_DIRECT) begin
      chk("ignored_state", 32'(dbg_state), 32'h0);
      chk("ignored_busy", 32'(busy), 32'h0);
      repeat (3) @(posedge clk);
    end
  endtask

  initial begin
    int sel, mm, drain;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {red_out, green_out, blue_out, white_out}, 32'h0);
    chk("reset_flags", {30'h0, busy, valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'h0);

    issue(M_DIRECT, 0, 8'h78, 0, 8'h12, 8'h34, 8'h56, -1, 1'b0);
    issue(M_HUE, 0, 0, 8'hFF, 0, 0, 0, -1, 1'b0);
    issue(M_HUE, 40, 0, 8'hFF, 0, 0, 0, -1, 1'b0);
    issue(M_HUE, 108, 8'h10, 8'hFF, 0, 0, 0, -1, 1'b0);
    issue(M_HUE, 0, 0, 8'h7F, 0, 0, 0, -1, 1'b0);
    issue(M_HUE, 8'hFA, 0, 8'hFF, 0, 0, 0, -1, 1'b0);
    issue(M_HUE, 0, 8'h20, 8'h00, 0, 0, 0, -1, 1'b0);
    issue(8'h55, 10, 1, 2, 3, 4, 5, -1, 1'b0);
    issue(M_HUE, 30, 8'h05, 8'hC0, 0, 0, 0, 4, 1'b0);
    issue(M_HUE, 0, 8'h40, 8'hFF, 0, 0, 0, -1, 1'b1);
    issue(M_DIRECT, 0, 8'h01, 0, 8'hAA, 8'h55, 8'h00, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        issue(M_DIRECT, 0, $urandom_range(0, 255), 0, $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), -1, 1'b0);
      end else if (sel < 8) begin
        issue(M_HUE, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              0, 0, 0, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1, 1'b0);
      end else begin
        mm = $urandom_range(0, 255);
        if (mm == 32'(M_DIRECT) || mm == 32'(M_HUE)) mm = 8'h00;
        issue(8'(mm), $urandom_range(0, 255), 0, 0, 0, 0, 0, -1, 1'b0);
      end
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 300) begin
      @(posedge clk);
      drain++;
    end
    repeat (3) @(posedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
